hc_read_response: RTL and testbench

Read-response stage for the hc accelerator data path. It sits directly downstream of the hc read requestor:
- consumes CCI-P channel-0 read responses;
- buffers them in a FIFO with credit accounting against requests the requestor has issued;
- presents cache lines to the core through a valid/ready interface.

It also drives a stall back to the requestor so that responses, which cannot be back-pressured, never overflow the buffer.

---
 rtl/hc_read_response.sv | 147 ++++++++++++++
 tb/tb_hc_read_response.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_read_response.sv
// hc_read_response: CCI-P channel-0 read-response buffer with credit tracking,
// a single-stage valid/ready output register and a requestor stall.
`default_nettype none

module hc_read_response #(
  parameter int HC_RSP_DATA_WIDTH = 512,
  parameter int HC_RSP_TAG_WIDTH  = 16,
  parameter int HC_RSP_DEPTH      = 64,
  parameter int HC_RSP_SLACK      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_issue,
  input  logic                              rsp_valid,
  input  logic                              rsp_is_read,
  input  logic [HC_RSP_TAG_WIDTH-1:0]       rsp_tag,
  input  logic [HC_RSP_DATA_WIDTH-1:0]      rsp_data,
  output logic                              out_valid,
  output logic [HC_RSP_TAG_WIDTH-1:0]       out_tag,
  output logic [HC_RSP_DATA_WIDTH-1:0]      out_data,
  input  logic                              out_ready,
  output logic                              rd_stall,
  output logic [$clog2(HC_RSP_DEPTH):0]     outstanding,
  output logic [$clog2(HC_RSP_DEPTH):0]     occupancy,
  output logic                              idle,
  output logic                              err_overflow,
  output logic                              err_unexpected
);

  localparam int AW = $clog2(HC_RSP_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int EW = HC_RSP_TAG_WIDTH + HC_RSP_DATA_WIDTH;

  localparam logic [CW-1:0] DEPTH_C    = CW'(HC_RSP_DEPTH);
  localparam logic [CW-1:0] OUTST_MAX  = {CW{1'b1}};
  localparam logic [SW-1:0] STALL_LVL  = SW'(HC_RSP_DEPTH - HC_RSP_SLACK);

  typedef enum logic [0:0] {
    S_OUT_EMPTY = 1'b0,
    S_OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t        state, state_nxt;
  logic [EW-1:0]     mem [HC_RSP_DEPTH];
  logic [EW-1:0]     head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic [CW-1:0]     outstanding_nxt;
  logic [SW-1:0]     stall_sum;
  logic              accept, push, pop, load, xfer, fifo_nonempty;
  logic              drop, unexpected;

  assign out_valid = (state == S_OUT_FULL);
  assign occupancy = count;
  assign head      = mem[rd_ptr];

  // One bit wider than the counters so the sum can never wrap.
  assign stall_sum = {1'b0, outstanding} + {1'b0, count} + SW'(out_valid);
  assign rd_stall  = (stall_sum >= STALL_LVL);

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    accept        = rsp_valid & rsp_is_read;
    fifo_nonempty = (count != '0);
    xfer          = out_valid & out_ready;

    case (state)
      S_OUT_EMPTY: begin
        if (fifo_nonempty) begin
          load      = 1'b1;
          state_nxt = S_OUT_FULL;
        end
      end
      S_OUT_FULL: begin
        if (xfer) begin
          if (fifo_nonempty) begin
            load = 1'b1;
          end else begin
            state_nxt = S_OUT_EMPTY;
          end
        end
      end
      default: state_nxt = S_OUT_EMPTY;
    endcase

    pop       = load;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    push      = accept & ((count < DEPTH_C) | pop);
    drop      = accept & ~push;
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    outstanding_nxt = outstanding;
    unexpected      = 1'b0;
    case ({req_issue, accept})
      2'b10: begin
        if (outstanding == OUTST_MAX) unexpected = 1'b1;
        else                          outstanding_nxt = outstanding + 1'b1;
      end
      2'b01: begin
        if (outstanding == '0) unexpected = 1'b1;
        else                   outstanding_nxt = outstanding - 1'b1;
      end
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_OUT_EMPTY;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      outstanding    <= '0;
      out_tag        <= '0;
      out_data       <= '0;
      idle           <= 1'b1;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (load) begin
        out_tag  <= head[EW-1 -: HC_RSP_TAG_WIDTH];
        out_data <= head[HC_RSP_DATA_WIDTH-1:0];
      end
      idle <= (outstanding_nxt == '0) && (count_nxt == '0) &&
              (state_nxt == S_OUT_EMPTY);
      if (drop)       err_overflow   <= 1'b1;
      if (unexpected) err_unexpected <= 1'b1;
    end
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rsp_tag, rsp_data};
  end

endmodule

`default_nettype wire

// File: tb/tb_hc_read_response.sv
// Directed self-checking bench for hc_read_response (DEPTH 64, SLACK 8).
`default_nettype none

module tb_hc_read_response;

  localparam int DW    = 512;
  localparam int TW    = 16;
  localparam int DEPTH = 64;
  localparam int SLACK = 8;
  localparam int CW    = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req_issue, rsp_valid, rsp_is_read, out_ready;
  logic [TW-1:0]  rsp_tag;
  logic [DW-1:0]  rsp_data;
  logic           out_valid, rd_stall, idle, err_overflow, err_unexpected;
  logic [TW-1:0]  out_tag;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  outstanding, occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hc_read_response #(
    .HC_RSP_DATA_WIDTH(DW),
    .HC_RSP_TAG_WIDTH (TW),
    .HC_RSP_DEPTH     (DEPTH),
    .HC_RSP_SLACK     (SLACK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_issue     (req_issue),
    .rsp_valid     (rsp_valid),
    .rsp_is_read   (rsp_is_read),
    .rsp_tag       (rsp_tag),
    .rsp_data      (rsp_data),
    .out_valid     (out_valid),
    .out_tag       (out_tag),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .rd_stall      (rd_stall),
    .outstanding   (outstanding),
    .occupancy     (occupancy),
    .idle          (idle),
    .err_overflow  (err_overflow),
    .err_unexpected(err_unexpected)
  );

  function automatic logic [DW-1:0] line_of(input int t);
    logic [31:0] w;
    w = 32'h5A5A_0000 ^ 32'(t) ^ (32'(t) << 20);
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    req_issue   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_is_read = 1'b0;
    rsp_tag     = '0;
    rsp_data    = '0;
  endtask

  task automatic do_reset();
    clear_in();
    out_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic issue(input int n);
    for (int i = 0; i < n; i++) begin
      req_issue = 1'b1;
      tick();
    end
    req_issue = 1'b0;
  endtask

  task automatic send_rsp(input int t);
    rsp_valid   = 1'b1;
    rsp_is_read = 1'b1;
    rsp_tag     = TW'(t);
    rsp_data    = line_of(t);
    tick();
    rsp_valid   = 1'b0;
    rsp_is_read = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    out_ready = 1'b0;
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, rd_stall, idle, err_overflow, err_unexpected} !== 5'b00100) begin
      $display("FAIL reset_flags: got %b expected 00100",
               {out_valid, rd_stall, idle, err_overflow, err_unexpected});
      n_err++;
    end
    n_cmp++;
    if (outstanding !== '0 || occupancy !== '0) begin
      $display("FAIL reset_counts: outstanding %0d occupancy %0d expected 0 0", outstanding, occupancy);
      n_err++;
    end
    n_cmp++;
    if (out_tag !== '0 || out_data !== '0) begin
      $display("FAIL reset_out: tag %h expected 0, data nonzero=%0b", out_tag, |out_data);
      n_err++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    do_reset();
    out_ready = 1'b1;
    issue(4);
    n_cmp++;
    if (outstanding !== 7'd4) begin
      $display("FAIL order_issue: outstanding %0d expected 4", outstanding);
      n_err++;
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        rsp_valid = 1'b1; rsp_is_read = 1'b1; rsp_tag = TW'(k); rsp_data = line_of(k);
      end else begin
        clear_in();
      end
      tick();
      n_cmp++;
      if (out_valid !== (k >= 1 && k <= 4)) begin
        $display("FAIL order_valid[%0d]: got %b expected %b", k, out_valid, (k >= 1 && k <= 4));
        n_err++;
      end
      if (k >= 1 && k <= 4) begin
        n_cmp++;
        if (out_tag !== TW'(k - 1) || out_data !== line_of(k - 1)) begin
          $display("FAIL order_line[%0d]: tag %0d expected %0d", k, out_tag, k - 1);
          n_err++;
        end
      end
      n_cmp++;
      if (occupancy !== ((k <= 3) ? 7'd1 : 7'd0) || outstanding !== ((k <= 3) ? 7'(3 - k) : 7'd0)) begin
        $display("FAIL order_counts[%0d]: occupancy %0d outstanding %0d", k, occupancy, outstanding);
        n_err++;
      end
    end
    n_cmp++;
    if (idle !== 1'b1) begin
      $display("FAIL order_idle: got %b expected 1", idle);
      n_err++;
    end
  endtask

  task automatic test_stall();
    int early_drop;
    early_drop = 0;
    do_reset();
    out_ready = 1'b0;
    issue(DEPTH - SLACK - 1);
    n_cmp++;
    if (rd_stall !== 1'b0 || outstanding !== 7'(DEPTH - SLACK - 1)) begin
      $display("FAIL stall_below: stall %b outstanding %0d expected 0 55", rd_stall, outstanding);
      n_err++;
    end
    issue(1);
    n_cmp++;
    if (rd_stall !== 1'b1) begin
      $display("FAIL stall_at_level: got %b expected 1", rd_stall);
      n_err++;
    end
    for (int i = 0; i < DEPTH - SLACK; i++) begin
      send_rsp(i);
      if (rd_stall !== 1'b1) early_drop++;
    end
    tick();
    tick();
    n_cmp++;
    if (early_drop != 0) begin
      $display("FAIL stall_hold: stall dropped on %0d cycles expected 0", early_drop);
      n_err++;
    end
    n_cmp++;
    if (occupancy !== 7'd55 || outstanding !== 7'd0 || out_valid !== 1'b1 || rd_stall !== 1'b1) begin
      $display("FAIL stall_final: occ %0d outst %0d valid %b stall %b expected 55 0 1 1",
               occupancy, outstanding, out_valid, rd_stall);
      n_err++;
    end
    n_cmp++;
    if (err_overflow !== 1'b0 || err_unexpected !== 1'b0) begin
      $display("FAIL stall_errors: ovf %b unexp %b expected 0 0", err_overflow, err_unexpected);
      n_err++;
    end
    n_cmp++;
    if (out_tag !== '0 || out_data !== line_of(0)) begin
      $display("FAIL stall_stable: tag %0d expected 0", out_tag);
      n_err++;
    end
  endtask

  task automatic test_overflow();
    int bad;
    bad = 0;
    do_reset();
    out_ready = 1'b0;
    issue(DEPTH + 2);
    for (int i = 0; i < DEPTH + 1; i++) send_rsp(i);
    n_cmp++;
    if (occupancy !== 7'd64 || out_valid !== 1'b1 || err_overflow !== 1'b0) begin
      $display("FAIL ovf_full: occ %0d valid %b ovf %b expected 64 1 0", occupancy, out_valid, err_overflow);
      n_err++;
    end
    send_rsp(DEPTH + 1);
    tick();
    n_cmp++;
    if (occupancy !== 7'd64 || err_overflow !== 1'b1 || err_unexpected !== 1'b0 || outstanding !== 7'd0) begin
      $display("FAIL ovf_drop: occ %0d ovf %b unexp %b outst %0d expected 64 1 0 0",
               occupancy, err_overflow, err_unexpected, outstanding);
      n_err++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (out_valid !== 1'b1 || out_tag !== TW'(i) || out_data !== line_of(i)) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      $display("FAIL ovf_drain: %0d of 65 lines wrong expected 0", bad);
      n_err++;
    end
    n_cmp++;
    if (out_valid !== 1'b0 || err_overflow !== 1'b1) begin
      $display("FAIL ovf_after: valid %b ovf %b expected 0 1", out_valid, err_overflow);
      n_err++;
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    out_ready = 1'b1;
    send_rsp(7);
    n_cmp++;
    if (err_unexpected !== 1'b1 || outstanding !== 7'd0 || occupancy !== 7'd1) begin
      $display("FAIL unexp_rsp: unexp %b outst %0d occ %0d expected 1 0 1",
               err_unexpected, outstanding, occupancy);
      n_err++;
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_tag !== 16'd7) begin
      $display("FAIL unexp_line: valid %b tag %0d expected 1 7", out_valid, out_tag);
      n_err++;
    end
    issue(2);
    req_issue = 1'b1;
    send_rsp(8);
    req_issue = 1'b0;
    n_cmp++;
    if (outstanding !== 7'd2) begin
      $display("FAIL unexp_same_cycle: outstanding %0d expected 2", outstanding);
      n_err++;
    end
  endtask

  task automatic test_non_read();
    tick();
    tick();
    tick();
    rsp_valid = 1'b1; rsp_is_read = 1'b0; rsp_tag = 16'd9; rsp_data = line_of(9);
    tick();
    clear_in();
    n_cmp++;
    if (occupancy !== 7'd0 || outstanding !== 7'd2) begin
      $display("FAIL nonread_counts: occ %0d outst %0d expected 0 2", occupancy, outstanding);
      n_err++;
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      $display("FAIL nonread_valid: got %b expected 0", out_valid);
      n_err++;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    issue(10);
    for (int i = 0; i < 10; i++) send_rsp(100 + i);
    n_cmp++;
    if (occupancy !== 7'd9 || out_valid !== 1'b1) begin
      $display("FAIL mid_fill: occ %0d valid %b expected 9 1", occupancy, out_valid);
      n_err++;
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== '0 || outstanding !== '0 || idle !== 1'b1 ||
        out_data !== '0 || out_tag !== '0 || rd_stall !== 1'b0) begin
      $display("FAIL mid_async: valid %b occ %0d outst %0d idle %b tag %0d",
               out_valid, occupancy, outstanding, idle, out_tag);
      n_err++;
    end
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== '0 || idle !== 1'b1) begin
      $display("FAIL mid_stale: valid %b occ %0d idle %b expected 0 0 1", out_valid, occupancy, idle);
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_stall();
    test_overflow();
    test_unexpected();
    test_non_read();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
